// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: decodes command bytes, drives the GPIO
// expander register bank and returns read data to the SPI shift stage.
module spi_reg_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int IN_SYNC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic [7:0] gpio_oe,
    output logic       irq,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WR, S_RD, S_ERR
    } state_e;

    localparam logic [ADDR_W-1:0] A_OUT = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_IN  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_MSK = ADDR_W'(3);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        out_q, out_d;
    logic [7:0]        dir_q, dir_d;
    logic [7:0]        msk_q, msk_d;
    logic [7:0]        txb_q, txb_d;
    logic              txl_q, txl_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;
    logic [7:0]        sync_q [IN_SYNC];
    logic [7:0]        in_prev_q;

    logic [7:0]        in_sync;
    logic [ADDR_W-1:0] cmd_addr, addr_nx, rd_addr;
    logic              cmd_wr, cmd_bad, chg;
    logic [7:0]        rd_data;
    logic              load;

    assign in_sync  = sync_q[IN_SYNC-1];
    assign cmd_wr   = rx_byte[7];
    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign cmd_bad  = |rx_byte[6:ADDR_W];
    assign addr_nx  = addr_q + ADDR_W'(1);
    assign chg      = |((in_sync ^ in_prev_q) & msk_q);

    // Read address: command address on the command byte, else the next burst slot
    always_comb begin
        rd_addr = addr_nx;
        if (state_q == S_CMD) rd_addr = cmd_addr;
    end

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr == A_OUT) rd_data = out_q;
        else if (rd_addr == A_DIR) rd_data = dir_q;
        else if (rd_addr == A_IN) rd_data = in_sync;
        else if (rd_addr == A_MSK) rd_data = msk_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        out_d   = out_q;
        dir_d   = dir_q;
        msk_d   = msk_q;
        txb_d   = txb_q;
        txl_d   = 1'b0;
        err_d   = err_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!en) begin
                    state_d = S_CMD;
                    err_d   = 1'b0;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    addr_d = cmd_addr;
                    if (cmd_bad) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (cmd_wr) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                        load    = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (rx_valid) begin
                    addr_d = addr_nx;
                    if (addr_q == A_OUT) out_d = rx_byte;
                    else if (addr_q == A_DIR) dir_d = rx_byte;
                    else if (addr_q == A_MSK) msk_d = rx_byte;
                    else if (addr_q == A_IN) err_d = 1'b1;
                end
            end
            S_RD: begin
                if (rx_valid) begin
                    addr_d = addr_nx;
                    load   = 1'b1;
                end
            end
            S_ERR: ;
            default: state_d = S_IDLE;
        endcase
        // Frame end wins over state, after the coincident byte is handled
        if (state_q != S_IDLE && en) state_d = S_IDLE;
        if (load) begin
            txl_d = 1'b1;
            txb_d = rd_data;
        end
    end

    always_comb begin
        irq_d = irq_q;
        if (load && rd_addr == A_IN) irq_d = 1'b0;
        if (chg) irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            out_q   <= 8'h00;
            dir_q   <= 8'h00;
            msk_q   <= 8'h00;
            txb_q   <= 8'h00;
            txl_q   <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            msk_q   <= msk_d;
            txb_q   <= txb_d;
            txl_q   <= txl_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IN_SYNC; i++) sync_q[i] <= 8'h00;
            in_prev_q <= 8'h00;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < IN_SYNC; i++) sync_q[i] <= sync_q[i-1];
            in_prev_q <= in_sync;
        end
    end

    assign tx_byte  = txb_q;
    assign tx_load  = txl_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;
    assign err      = err_q;

endmodule
